// File: rtl/divider_if.sv
`default_nettype none
// ============================================================================
// Module      : divider_if
// Description : Operand, strobe and result bundle for the sequential divider.
// Revision    : 1.0
// ============================================================================
interface divider_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             data_busy;

    modport master (
        output data_operandA,
        output data_operandB,
        output ctrl_DIV,
        input  data_result,
        input  data_exception,
        input  data_resultRDY,
        input  data_busy
    );

    modport slave (
        input  data_operandA,
        input  data_operandB,
        input  ctrl_DIV,
        output data_result,
        output data_exception,
        output data_resultRDY,
        output data_busy
    );
endinterface
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// ============================================================================
// Module      : divider
// Description : Sequential signed restoring divider, one quotient bit/cycle.
// Revision    : 1.0
// ============================================================================
module divider #(
    parameter int WIDTH = 32
) (
    input  logic      clock,
    input  logic      reset,
    divider_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [WIDTH-1:0] c_minVal = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] c_allOne = {WIDTH{1'b1}};

    logic [1:0]       r_state;
    logic [1:0]       w_stateNext;

    logic [WIDTH-1:0] r_div;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_negQ;
    logic             r_exc;

    logic [WIDTH-1:0] r_result;
    logic             r_exception;
    logic             r_resultRdy;

    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;
    logic             w_excCond;
    logic [WIDTH+1:0] w_trial;
    logic             w_lastIter;

    // |x| as plain two's-complement negation; the most negative value maps
    // onto itself, which reads correctly as unsigned 2^(WIDTH-1).
    assign w_absA = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + 1'b1) : bus.data_operandA;
    assign w_absB = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + 1'b1) : bus.data_operandB;

    assign w_excCond = (bus.data_operandB == '0) ||
                       ((bus.data_operandA == c_minVal) && (bus.data_operandB == c_allOne));

    // Trial subtraction carries one extra bit so its sign decides restore.
    assign w_trial    = {r_rem, r_quo[WIDTH-1]} - {2'b00, r_div};
    assign w_lastIter = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:  w_stateNext = S_IDLE;
            S_RUN:   if (w_lastIter) w_stateNext = S_FIX;
            S_FIX:   w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
        if (bus.ctrl_DIV) begin
            w_stateNext = w_excCond ? S_FIX : S_RUN;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_cnt       <= '0;
            r_negQ      <= 1'b0;
            r_exc       <= 1'b0;
            r_result    <= '0;
            r_exception <= 1'b0;
            r_resultRdy <= 1'b0;
        end else if (bus.ctrl_DIV) begin
            r_div       <= w_absB;
            r_quo       <= w_absA;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_negQ      <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            r_exc       <= w_excCond;
            r_result    <= '0;
            r_exception <= 1'b0;
            r_resultRdy <= 1'b0;
        end else begin
            r_resultRdy <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (!w_trial[WIDTH+1]) begin
                        r_rem <= w_trial[WIDTH:0];
                    end else begin
                        r_rem <= {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
                    end
                    r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH+1]};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    if (r_exc) begin
                        r_result <= '0;
                    end else if (r_negQ) begin
                        r_result <= ~r_quo + 1'b1;
                    end else begin
                        r_result <= r_quo;
                    end
                    r_exception <= r_exc;
                    r_resultRdy <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exception;
    assign bus.data_resultRDY = r_resultRdy;
    assign bus.data_busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider
// Description : Directed scoreboard bench for the sequential divider.
// Revision    : 1.0
// ============================================================================
module tb_divider;
    logic clock = 1'b0;
    logic reset = 1'b1;

    divider_if #(.WIDTH(32)) ifc ();

    divider #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          lat;
    } exp_t;

    exp_t sbQ[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sa;
        int   sb;
        sa = a;
        sb = b;
        if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
            e.res = 32'd0;
            e.exc = 1'b1;
            e.lat = 1;
        end else begin
            e.res = sa / sb;
            e.exc = 1'b0;
            e.lat = 33;
        end
        return e;
    endfunction

    // Called at a negedge; the following posedge samples the start.
    task automatic pulseStart(input logic [31:0] a, input logic [31:0] b);
        ifc.data_operandA = a;
        ifc.data_operandB = b;
        ifc.ctrl_DIV      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ifc.ctrl_DIV      = 1'b0;
    endtask

    task automatic waitResult(input string tag);
        int   k;
        logic seen;
        exp_t e;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(posedge clock);
            @(negedge clock);
            k++;
            seen = ifc.data_resultRDY;
        end
        if (!seen) begin
            chk({tag, "_rdyTimeout"}, 32'd0, 32'd1);
            if (sbQ.size() > 0) void'(sbQ.pop_front());
        end else begin
            e = sbQ.pop_front();
            chk({tag, "_latency"}, k, e.lat);
            chk({tag, "_result"}, ifc.data_result, e.res);
            chk({tag, "_exception"}, {31'd0, ifc.data_exception}, {31'd0, e.exc});
            chk({tag, "_busyDone"}, {31'd0, ifc.data_busy}, 32'd0);
        end
    endtask

    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b);
        sbQ.push_back(model(a, b));
        pulseStart(a, b);
        chk({tag, "_rdyLowAtStart"}, {31'd0, ifc.data_resultRDY}, 32'd0);
        chk({tag, "_resultCleared"}, ifc.data_result, 32'd0);
        chk({tag, "_busy"}, {31'd0, ifc.data_busy}, 32'd1);
        waitResult(tag);
    endtask

    initial begin
        logic anyRdy;
        ifc.data_operandA = 32'd0;
        ifc.data_operandB = 32'd0;
        ifc.ctrl_DIV      = 1'b0;

        repeat (2) @(negedge clock);
        chk("rst_result", ifc.data_result, 32'd0);
        chk("rst_exception", {31'd0, ifc.data_exception}, 32'd0);
        chk("rst_rdy", {31'd0, ifc.data_resultRDY}, 32'd0);
        chk("rst_busy", {31'd0, ifc.data_busy}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        runOp("p100_7", 32'd100, 32'd7);
        @(posedge clock);
        @(negedge clock);
        chk("p100_7_rdyOneCycle", {31'd0, ifc.data_resultRDY}, 32'd0);
        chk("p100_7_resultHold", ifc.data_result, 32'd14);

        runOp("m100_7", -32'sd100, 32'd7);
        runOp("p100_m7", 32'd100, -32'sd7);
        runOp("m100_m7", -32'sd100, -32'sd7);
        runOp("p7_m100", 32'd7, -32'sd100);
        runOp("min_2", 32'h8000_0000, 32'd2);
        runOp("max_1", 32'h7FFF_FFFF, 32'd1);
        runOp("div0", 32'd1234, 32'd0);
        runOp("p9_3", 32'd9, 32'd3);
        runOp("ovf", 32'h8000_0000, 32'hFFFF_FFFF);

        // Restart: the aborted 1000/10 must never report.
        anyRdy = 1'b0;
        pulseStart(32'd1000, 32'd10);
        repeat (9) begin
            @(posedge clock);
            @(negedge clock);
            anyRdy = anyRdy | ifc.data_resultRDY;
        end
        runOp("restart81_9", 32'd81, 32'd9);
        chk("restart_noEarlyRdy", {31'd0, anyRdy}, 32'd0);

        // Asynchronous reset in the middle of a RUN.
        pulseStart(32'd50, 32'd5);
        repeat (5) begin
            @(posedge clock);
            @(negedge clock);
        end
        #1 reset = 1'b1;
        #1;
        chk("midRst_result", ifc.data_result, 32'd0);
        chk("midRst_exception", {31'd0, ifc.data_exception}, 32'd0);
        chk("midRst_rdy", {31'd0, ifc.data_resultRDY}, 32'd0);
        chk("midRst_busy", {31'd0, ifc.data_busy}, 32'd0);
        @(negedge clock);
        reset  = 1'b0;
        anyRdy = 1'b0;
        repeat (40) begin
            @(posedge clock);
            @(negedge clock);
            anyRdy = anyRdy | ifc.data_resultRDY;
        end
        chk("midRst_noRdy", {31'd0, anyRdy}, 32'd0);
        runOp("p15_4", 32'd15, 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/divider.md
# divider

Sequential signed 32-bit integer divider: the division half of the multiply/divide unit, paired with the radix-4 Booth multiplier. It accepts a one-cycle `ctrl_DIV` start pulse and computes `data_operandA / data_operandB` iteratively, one quotient bit per cycle. It returns the quotient truncated toward zero with a one-cycle ready pulse. Divide-by-zero and the single overflow case raise `data_exception`.

## Interface
Parameters:
- `WIDTH`, 32: operand and quotient width. Only 32 is verified.

Ports:
- `clock`  in  1  sole clock, rising-edge.
- `reset`  in  1  asynchronous, active-high. Returns the block to IDLE and clears all outputs.
- `data_operandA`  in  32  dividend, two's complement. Sampled only on the start edge.
- `data_operandB`  in  32  divisor, two's complement. Sampled only on the start edge.
- `ctrl_DIV`  in  1  start strobe. Sampled every rising edge.
- `data_result`  out  32  quotient, two's complement. Registered.
- `data_exception`  out  1  error flag for the last completed operation. Registered.
- `data_resultRDY`  out  1  one-cycle completion pulse. Registered.
- `data_busy`  out  1  high while an operation is in flight (RUN or FIX).

## Operation
- States: IDLE, RUN, FIX.
- Datapath registers:
  - `M`: 32-bit divisor magnitude.
  - `R`: 33-bit partial remainder.
  - `Q`: 32-bit dividend/quotient shift register.
  - `cnt`: 6-bit iteration counter.
  - `negQ`: quotient sign.
  - `exc`: pending exception.
- Start: on any edge with `ctrl_DIV`=1, regardless of state (a start while busy aborts and restarts):
  - `M`=|B|, `Q`=|A|, `R`=0, `cnt`=0.
  - `negQ` = A[31] XOR B[31].
  - Clear `data_result`, `data_exception` and `data_resultRDY` to 0.
  - If B==0, or A==0x80000000 with B==0xFFFFFFFF: set `exc`=1 and go to FIX.
  - Otherwise: set `exc`=0 and go to RUN.
- Magnitudes: |x| is computed as 32-bit two's-complement negation. |0x80000000| = 0x80000000, treated as unsigned 2^31. This is correct for every non-exception case.
- RUN iteration, one per edge (restoring division):
  - Shift `{R,Q}` left by 1.
  - Compute T = R_shifted − {0,M} (33-bit).
  - If T[32]==0: R=T and Q[0]=1. Otherwise R is unchanged and Q[0]=0.
  - `cnt`++. When `cnt` reaches 32, go to FIX.
- FIX (one edge), then return to IDLE:
  - `data_result` = `exc` ? 0 : (`negQ` ? −Q : Q).
  - `data_exception` = `exc`.
  - `data_resultRDY` = 1.
- Outputs hold: `data_result` and `data_exception` hold until the next accepted start or reset. `data_resultRDY` clears on the edge after it rises.
- Remainder: computed in `R` but not exported. Quotient sign follows C semantics (truncation toward zero).
- `ctrl_DIV` held high for several cycles restarts the operation on every such edge. The result is reported only after the last high edge.

## Timing
- Reset: state=IDLE. `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `data_busy`=0. All internal registers are cleared.
- Let E0 be the edge that samples `ctrl_DIV`=1.
- Normal operation:
  - RUN iterations occur on edges E1..E32.
  - FIX occurs at E33. `data_resultRDY`=1 and the valid result are visible during the cycle after E33.
  - `data_resultRDY` returns to 0 at E34.
  - `data_busy`=1 from after E0 until after E33.
- Exception cases:
  - FIX occurs at E1. `data_resultRDY`=1 during the cycle after E1, with `data_exception`=1 and `data_result`=0.
- Restart: a start at any edge during RUN or FIX supersedes the in-flight operation. No `data_resultRDY` is produced for the aborted operation.
- Reset mid-operation: asynchronous. Outputs go to 0 immediately, without waiting for a clock edge. No ready pulse is produced until a new start.
- Back-to-back: a start on the same edge that `data_resultRDY` falls (E34) is legal and needs no idle cycle.

## Test plan
- 100 / 7 → `data_result`=14, `data_exception`=0. `data_resultRDY` is high exactly during the cycle after E33, and high for exactly one cycle.
- Sign mix: −100 / 7 → −14; 100 / −7 → −14; −100 / −7 → 14; 7 / −100 → 0; 0x80000000 / 2 → 0xC0000000; 0x7FFFFFFF / 1 → 0x7FFFFFFF.
- 1234 / 0 → `data_exception`=1, `data_result`=0, with `data_resultRDY` in the cycle after E1. A following 9 / 3 → 3 with `data_exception` back to 0.
- 0x80000000 / 0xFFFFFFFF → `data_exception`=1, `data_result`=0, ready after E1.
- Start 1000 / 10, then a new start 81 / 9 at E10 → a single `data_resultRDY`, 33 edges after the second start, with result 9. No pulse for 1000 / 10.
- Assert `reset` between edges mid-RUN → all outputs 0 before the next edge. No `data_resultRDY` follows. A subsequent 15 / 4 → 3.
